// File: rtl/prog_loader.sv
// Program loader: writes a framed byte stream (addr, len, payload[, csum]) into instruction memory
// and holds the CPU in reset until the frame is complete. Optional checksum byte via LOADER_CSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = DATA_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd5;
`ifdef LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              xfer;
`ifdef LOADER_CSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] csum_total;
  logic              err_q, err_d;
`endif

`ifdef LOADER_CSUM_EN
  assign in_ready = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign in_ready = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA);
`endif

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
`ifdef LOADER_CSUM_EN
    sum_d      = sum_q;
    err_d      = err_q;
    csum_total = sum_q + in_data;
`endif
    case (state_q)
      S_ADDR: begin
        if (xfer) begin
          ptr_d   = ADDR_W'(in_data);
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          // A length byte of zero encodes a full 2^DATA_W-byte payload.
          if (in_data == '0) cnt_d = {1'b1, {DATA_W{1'b0}}};
          else               cnt_d = {1'b0, in_data};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_addr_d = ptr_q;
          mem_data_d = in_data;
          mem_we_d   = 1'b1;
          ptr_d      = ptr_q + ADDR_W'(1);
          cnt_d      = cnt_q - CNT_W'(1);
`ifdef LOADER_CSUM_EN
          sum_d      = sum_q + in_data;
          if (cnt_q == CNT_W'(1)) state_d = S_CSUM;
`else
          // Without a checksum the final payload write and done land on the same edge.
          if (cnt_q == CNT_W'(1)) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end
`endif
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (csum_total == '0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_ADDR;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          sum_d      = '0;
        end
      end
`else
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_ADDR;
          done_d     = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
`ifdef LOADER_CSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
`ifdef LOADER_CSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the 8-bit CPU. It is the writer side of the instruction memory that the CPU fetches from through `rom_address`. It accepts a framed byte stream over a valid/ready handshake and writes the payload into consecutive instruction-memory locations. It holds the CPU in reset until a complete frame has been received and checked.

## Interface

Parameters:
- `ADDR_W`, 8: instruction-memory address width.
- `DATA_W`, 8: instruction word / stream byte width.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a load.
- `in_data`, in, DATA_W: stream byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `mem_addr`, out, ADDR_W: instruction-memory write address.
- `mem_data`, out, DATA_W: instruction-memory write data.
- `mem_we`, out, 1: one-cycle write strobe.
- `cpu_hold`, out, 1: high keeps the CPU in reset.
- `done`, out, 1: last load completed successfully; sticky.
- `err`, out, 1: last load failed its checksum; sticky.

## Operation

- Frame format, in order:
  - Byte 0: start address.
  - Byte 1: length. 0 means 256.
  - Next `length` bytes: payload.
  - Final byte: checksum. Present only with `LOADER_CSUM_EN`.
- Checksum rule: the 8-bit sum of all payload bytes plus the checksum byte must equal 0 mod 256.
- States: IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR.
- A transfer is a cycle where `in_valid` & `in_ready` are both high.
- `in_ready` is high exactly in ADDR, LEN, DATA and CSUM. It is driven combinationally from the state register.
- IDLE/DONE/ERR + `start` goes to ADDR:
  - `done` and `err` clear.
  - `cpu_hold` sets to 1.
  - The running sum clears.
- `start` is ignored in ADDR, LEN, DATA and CSUM.
- ADDR: on a transfer, the write pointer is loaded with the byte; go to LEN.
- LEN: on a transfer, the remaining count is set to the byte, with 0 mapped to 256 (9-bit counter); go to DATA.
- DATA: on each transfer:
  - `mem_addr` gets the pointer.
  - `mem_data` gets the byte.
  - `mem_we` is pulsed.
  - The pointer increments mod 2^ADDR_W (0xFF wraps to 0x00).
  - The sum adds the byte mod 256.
  - The remaining count decrements.
  - On the transfer that brings the count to 0, go to CSUM.
- CSUM: on a transfer:
  - If the sum plus the byte is 0 mod 256, go to DONE: `done`=1, `cpu_hold`=0.
  - Otherwise go to ERR: `err`=1, `cpu_hold` stays 1.
- Payload writes are never rolled back on error.
- DONE and ERR hold until the next `start`.
- Reset asserted at any time, including mid-frame, aborts the load immediately and forces reset values. A partially written memory is left as is.

## Timing

- Reset values:
  - State: IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - `cpu_hold`=1, `done`=0, `err`=0.
- All outputs except `in_ready` are registered.
- `start` sampled in cycle N gives `in_ready`=1 in cycle N+1.
- A DATA transfer in cycle N gives `mem_we`=1 with the matching `mem_addr`/`mem_data` in cycle N+1, for exactly one cycle.
- Back-to-back transfers give one write per cycle. Throughput is 1 byte/cycle.
- `in_valid` low stalls the frame without limit; state and counters hold.
- A checksum transfer in cycle N gives `done` or `err`, plus the `cpu_hold` update, in cycle N+1.
- The last payload write (N+1 of its transfer) always precedes or coincides with `done`. No writes occur after `done`.
- `start` and reset deassertion in the same edge: reset wins. `start` is seen from the first edge after reset deasserts.

## Configuration

- `LOADER_CSUM_EN`, defined:
  - The checksum byte is expected and verified, as above.
- `LOADER_CSUM_EN`, undefined:
  - No CSUM state and no sum register.
  - The final payload transfer goes directly to DONE: `done`=1 and `cpu_hold`=0 in the same cycle as the final `mem_we`.
  - `err` is tied to 0.

## Test plan

- Reset:
  - Stimulus: assert `reset` low mid-cycle with no clock.
  - Required: outputs immediately `cpu_hold`=1, `in_ready`=0, `mem_we`=0, `done`=0, `err`=0.
- Good frame:
  - Stimulus: `start`, then bytes 0x10, 0x03, 0x2F, 0x01, 0x00, 0xD0.
  - Required: writes 0x10=0x2F, 0x11=0x01, 0x12=0x00; then `done`=1, `cpu_hold`=0, `err`=0.
- Bad checksum:
  - Stimulus: same frame with last byte 0x00.
  - Required: all three writes occur; `err`=1, `done`=0, `cpu_hold`=1.
- Wrap and length 0:
  - Stimulus A: frame with address 0xFE, length 4.
  - Required A: writes at 0xFE, 0xFF, 0x00, 0x01.
  - Stimulus B: length 0x00.
  - Required B: exactly 256 writes, 0x00 through 0xFF, before CSUM.
- Backpressure/abort:
  - Stimulus: random `in_valid` gaps.
  - Required: identical writes, one per accepted byte.
  - Stimulus: `reset` asserted after 2 payload bytes.
  - Required: IDLE, `cpu_hold`=1, no further `mem_we`.
  - Stimulus: `start` pulsed mid-frame.
  - Required: ignored.
- Macro off:
  - Stimulus: `LOADER_CSUM_EN` undefined; bytes 0x10, 0x02, 0xAA, 0xBB.
  - Required: `done`=1 in the same cycle as the 0x11 write; the next byte is not accepted.
